// File: rtl/booth_mul_top_if.sv
// booth_mul_top_if: operand/product bundle for the 128x128 Booth multiplier.
// master drives the operands and observes the product; slave is the multiplier.
interface booth_mul_top_if;
  logic [127:0] a_i;
  logic [127:0] b_i;
  logic [255:0] mul_o;

  modport master (output a_i, output b_i, input mul_o);
  modport slave  (input a_i, input b_i, output mul_o);
endinterface

// File: rtl/booth_mul_top.sv
// booth_mul_top: unsigned 128x128 -> 256-bit multiplier.
// Radix-4 Booth recoding of b, a Wallace-style 3:2 carry-save tree and a
// final carry-propagate adder into a registered product.
// Optional build macro MUL_PIPE_EN: registers the tree's sum/carry vectors
// ahead of the final adder (latency 2 instead of 1, throughput unchanged).
module booth_mul_top (
  input  logic            clk_i,
  input  logic            rst_ni,
  booth_mul_top_if.slave  bus
);

  localparam int NUM_DIGITS = 65;
  localparam int NUM_ROWS   = NUM_DIGITS + 1;  // partial products + correction row
  localparam int NUM_LEVELS = 10;              // 66->44->30->20->14->10->7->5->4->3->2

  // Every partial product carries ~sign at bit 129+2k instead of a sign
  // extension; subtracting 2^(129+2k) for each digit restores the value.
  // All these bits lie at or above bit 129, so they never overlap the
  // negation corrections (even bits 0..128) and share one row with them.
  function automatic logic [255:0] sign_const();
    logic [255:0] c;
    c = 256'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((129 + 2 * k) < 256) begin
        c = c - (256'd1 << (129 + 2 * k));
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  localparam logic [255:0] C_SIGN = sign_const();

  // b zero-extended to 130 bits with the implicit b[-1] = 0 at index 0.
  logic [130:0] w_bx;
  logic [255:0] w_rows [0:NUM_ROWS-1];
  logic [255:0] w_sum;
  logic [255:0] w_carry;
  logic [255:0] r_mul;

  assign w_bx = {2'b00, bus.b_i, 1'b0};

  // Booth recode b into 65 digits and form the shifted partial products.
  always_comb begin
    logic [2:0]   trip;
    logic         one;
    logic         two;
    logic         neg;
    logic [128:0] sel;
    logic [129:0] ppv;
    logic [255:0] corr;
    corr = 256'd0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      w_rows[r] = 256'd0;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      trip = w_bx[2 * k +: 3];
      case (trip)
        3'b001, 3'b010: begin one = 1'b1; two = 1'b0; neg = 1'b0; end
        3'b011:         begin one = 1'b0; two = 1'b1; neg = 1'b0; end
        3'b100:         begin one = 1'b0; two = 1'b1; neg = 1'b1; end
        3'b101, 3'b110: begin one = 1'b1; two = 1'b0; neg = 1'b1; end
        default:        begin one = 1'b0; two = 1'b0; neg = 1'b0; end
      endcase
      if (one) begin
        sel = {1'b0, bus.a_i};
      end else if (two) begin
        sel = {bus.a_i, 1'b0};
      end else begin
        sel = 129'd0;
      end
      // Ones-complement for negative digits; the +1 goes into the correction row.
      ppv = {~neg, sel ^ {129{neg}}};
      w_rows[k] = {126'd0, ppv} << (2 * k);
      corr[2 * k] = neg;
    end
    w_rows[NUM_ROWS-1] = C_SIGN | corr;
  end

  // Carry-save tree: each level compresses groups of three rows into two.
  always_comb begin
    logic [255:0] lv [0:NUM_ROWS-1];
    logic [255:0] nx [0:NUM_ROWS-1];
    int n;
    int m;
    for (int r = 0; r < NUM_ROWS; r++) begin
      lv[r] = w_rows[r];
      nx[r] = 256'd0;
    end
    n = NUM_ROWS;
    for (int l = 0; l < NUM_LEVELS; l++) begin
      m = 0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        nx[r] = 256'd0;
      end
      for (int j = 0; j < 22; j++) begin
        if ((3 * j + 2) < n) begin
          nx[m]     = lv[3*j] ^ lv[3*j+1] ^ lv[3*j+2];
          nx[m + 1] = ((lv[3*j] & lv[3*j+1]) | (lv[3*j] & lv[3*j+2]) |
                       (lv[3*j+1] & lv[3*j+2])) << 1;
          m = m + 2;
        end else if ((3 * j) < n) begin
          // Leftover rows that do not fill a compressor pass straight down.
          nx[m] = lv[3*j];
          m = m + 1;
          if ((3 * j + 1) < n) begin
            nx[m] = lv[3*j+1];
            m = m + 1;
          end else begin
            m = m;
          end
        end else begin
          m = m;
        end
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
        lv[r] = nx[r];
      end
      n = m;
    end
    w_sum   = lv[0];
    w_carry = lv[1];
  end

`ifdef MUL_PIPE_EN
  logic [255:0] r_sum;
  logic [255:0] r_carry;

  // Capture the tree's redundant sum/carry pair; final add happens next stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sum   <= 256'd0;
      r_carry <= 256'd0;
    end else begin
      r_sum   <= w_sum;
      r_carry <= w_carry;
    end
  end

  // Final carry-propagate add into the product register; carry-out dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mul <= 256'd0;
    end else begin
      r_mul <= r_sum + r_carry;
    end
  end
`else
  // Final carry-propagate add into the product register; carry-out dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mul <= 256'd0;
    end else begin
      r_mul <= w_sum + w_carry;
    end
  end
`endif

  assign bus.mul_o = r_mul;

endmodule

// File: tb/tb_booth_mul_top.sv
// tb_booth_mul_top: directed and random checks of booth_mul_top.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. Honours MUL_PIPE_EN for the expected latency.
module tb_booth_mul_top;

`ifdef MUL_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [127:0] ONES   = 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff;
  localparam logic [127:0] A_HOLE = 128'hffff_ffff_ffff_ffff_ffff_ffff_fffe_ffff;
  localparam logic [255:0] MAXP   = {128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffe,
                                     128'h0000_0000_0000_0000_0000_0000_0000_0001};

  logic clk_i;
  logic rst_ni;
  int   n_tests;
  int   n_fail;

  booth_mul_top_if bus ();

  booth_mul_top dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Plain 256-bit arithmetic product, used where hand constants get unwieldy.
  function automatic logic [255:0] ref_mul(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] wa;
    logic [255:0] wb;
    wa = {128'd0, a};
    wb = {128'd0, b};
    return wa * wb;
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    bus.a_i = ONES;
    bus.b_i = ONES;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_tests++;
      if (bus.mul_o !== 256'd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, bus.mul_o, 256'd0);
      end
    end
    rst_ni = 1'b1;
    repeat (LAT) @(posedge clk_i);
    #1;
    n_tests++;
    if (bus.mul_o !== MAXP) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", bus.mul_o, MAXP);
    end
  endtask

  task automatic test_max();
    @(negedge clk_i);
    bus.a_i = ONES;
    bus.b_i = ONES;
    repeat (LAT) @(posedge clk_i);
    #1;
    n_tests++;
    if (bus.mul_o[255:128] !== 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffe) begin
      n_fail++;
      $display("FAIL max_upper: got %h expected %h", bus.mul_o[255:128],
               128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffe);
    end
    n_tests++;
    if (bus.mul_o[127:0] !== 128'd1) begin
      n_fail++;
      $display("FAIL max_lower: got %h expected %h", bus.mul_o[127:0], 128'd1);
    end
  endtask

  task automatic test_small();
    @(negedge clk_i);
    bus.a_i = 128'd2;
    bus.b_i = 128'd1;
    repeat (LAT) @(posedge clk_i);
    #1;
    n_tests++;
    if (bus.mul_o !== 256'd2) begin
      n_fail++;
      $display("FAIL small_2x1: got %h expected %h", bus.mul_o, 256'd2);
    end
    @(negedge clk_i);
    bus.a_i = ONES;
    bus.b_i = 128'd0;
    repeat (LAT) @(posedge clk_i);
    #1;
    n_tests++;
    if (bus.mul_o !== 256'd0) begin
      n_fail++;
      $display("FAIL zero_b: got %h expected %h", bus.mul_o, 256'd0);
    end
  endtask

  task automatic test_booth_digits();
    logic [255:0] exp_v;
    exp_v = {127'd0, 1'b1, 128'hffff_ffff_ffff_ffff_ffff_ffff_fffd_fffe};
    @(negedge clk_i);
    bus.a_i = A_HOLE;
    bus.b_i = 128'd2;
    repeat (LAT) @(posedge clk_i);
    #1;
    n_tests++;
    if (bus.mul_o !== exp_v) begin
      n_fail++;
      $display("FAIL booth_x2: got %h expected %h", bus.mul_o, exp_v);
    end
    @(negedge clk_i);
    bus.b_i = 128'haaaa_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa;
    exp_v = ref_mul(A_HOLE, 128'haaaa_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa);
    repeat (LAT) @(posedge clk_i);
    #1;
    n_tests++;
    if (bus.mul_o !== exp_v) begin
      n_fail++;
      $display("FAIL booth_aaaa: got %h expected %h", bus.mul_o, exp_v);
    end
    @(negedge clk_i);
    bus.b_i = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    exp_v = ref_mul(A_HOLE, 128'h5555_5555_5555_5555_5555_5555_5555_5555);
    repeat (LAT) @(posedge clk_i);
    #1;
    n_tests++;
    if (bus.mul_o !== exp_v) begin
      n_fail++;
      $display("FAIL booth_5555: got %h expected %h", bus.mul_o, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] bv   [0:2];
    logic [255:0] prod [0:2];
    bv[0] = 128'd5;  bv[1] = 128'd7;  bv[2] = 128'd9;
    prod[0] = 256'd15; prod[1] = 256'd21; prod[2] = 256'd27;
    for (int i = 0; i < 3 + LAT - 1; i++) begin
      @(negedge clk_i);
      if (i < 3) begin
        bus.a_i = 128'd3;
        bus.b_i = bv[i];
      end
      @(posedge clk_i);
      #1;
      if (i >= LAT - 1) begin
        n_tests++;
        if (bus.mul_o !== prod[i - LAT + 1]) begin
          n_fail++;
          $display("FAIL b2b[%0d]: got %h expected %h", i - LAT + 1, bus.mul_o,
                   prod[i - LAT + 1]);
        end
      end
    end
  endtask

  task automatic test_input_hold();
    @(negedge clk_i);
    bus.a_i = 128'd6;
    bus.b_i = 128'd7;
    repeat (LAT) @(posedge clk_i);
    #1;
    bus.a_i = 128'd11;
    bus.b_i = 128'd13;
    #2;
    n_tests++;
    if (bus.mul_o !== 256'd42) begin
      n_fail++;
      $display("FAIL input_hold: got %h expected %h", bus.mul_o, 256'd42);
    end
  endtask

  task automatic test_midstream_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      bus.a_i = ONES;
      bus.b_i = ONES - 128'(i);
    end
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if (bus.mul_o !== 256'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", bus.mul_o, 256'd0);
    end
    @(negedge clk_i);
    rst_ni  = 1'b1;
    bus.a_i = 128'd3;
    bus.b_i = 128'd7;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk_i);
      #1;
      if (e < LAT) begin
        n_tests++;
        if (bus.mul_o !== 256'd0) begin
          n_fail++;
          $display("FAIL reset_leak: got %h expected %h", bus.mul_o, 256'd0);
        end
      end else begin
        n_tests++;
        if (bus.mul_o !== 256'd21) begin
          n_fail++;
          $display("FAIL post_reset_first: got %h expected %h", bus.mul_o, 256'd21);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [255:0] exp_q [$];
    logic [255:0] exp_v;
    logic [127:0] a;
    logic [127:0] b;
    int n_ops;
    int shown;
    n_ops = 10000;
    shown = 0;
    for (int i = 0; i < n_ops + LAT - 1; i++) begin
      @(negedge clk_i);
      if (i < n_ops) begin
        if (i == 0) begin
          a = ONES;
          b = ONES;
        end else if (i == 1) begin
          a = ONES;
          a = a + 128'd1;
          b = a;
        end else if (i % 7 == 0) begin
          a = ONES >> $urandom_range(127, 0);
          b = ONES << $urandom_range(127, 0);
        end else begin
          a = {$urandom, $urandom, $urandom, $urandom};
          b = {$urandom, $urandom, $urandom, $urandom};
        end
        bus.a_i = a;
        bus.b_i = b;
        exp_q.push_back(ref_mul(a, b));
      end
      @(posedge clk_i);
      #1;
      if (i >= LAT - 1) begin
        exp_v = exp_q.pop_front();
        n_tests++;
        if (bus.mul_o !== exp_v) begin
          n_fail++;
          if (shown < 10) begin
            shown++;
            $display("FAIL random[%0d]: got %h expected %h", i - LAT + 1, bus.mul_o, exp_v);
          end
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_max();
    test_small();
    test_booth_digits();
    test_back_to_back();
    test_input_hold();
    test_midstream_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
